// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bus: pipeline-register fields and events into the
// hazard unit, stage enables/flushes and status counters back out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       idexMemRead;
  logic [4:0]       idexWriteReg;
  logic [4:0]       ifidRs;
  logic [4:0]       ifidRt;
  logic             ifidUsesRt;
  logic             jump;
  logic             branchTaken;
  logic             memBusy;
  logic             pcWrite;
  logic             ifidWrite;
  logic             ifidFlush;
  logic             idexWrite;
  logic             idexFlush;
  logic             memTimeout;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output idexMemRead, idexWriteReg, ifidRs, ifidRt, ifidUsesRt,
           jump, branchTaken, memBusy,
    input  pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush,
           memTimeout, stallCount, flushCount
  );

  modport slave (
    input  idexMemRead, idexWriteReg, ifidRs, ifidRt, ifidUsesRt,
           jump, branchTaken, memBusy,
    output pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush,
           memTimeout, stallCount, flushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stall, branch/jump flush and memory-wait hold,
// with a sticky memory timeout flag and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [7:0]       wait_cnt_r;
  logic [7:0]       wait_cnt_nxt_s;
  logic             timeout_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             load_use_s;
  logic             stall_inc_s;
  logic             flush_inc_s;
  logic             timeout_set_s;

  assign load_use_s = (hz.idexMemRead != 2'd0) && (hz.idexWriteReg != 5'd0) &&
                      ((hz.idexWriteReg == hz.ifidRs) ||
                       (hz.ifidUsesRt && (hz.idexWriteReg == hz.ifidRt)));

  assign timeout_set_s = hz.memBusy && (state_r == MEM_WAIT) && (wait_cnt_r >= TMO_LIMIT);

  // Next-state and stage controls; reset forces every enable and flush low at once.
  always_comb begin
    hz.pcWrite     = 1'b1;
    hz.ifidWrite   = 1'b1;
    hz.ifidFlush   = 1'b0;
    hz.idexWrite   = 1'b1;
    hz.idexFlush   = 1'b0;
    stall_inc_s    = 1'b0;
    flush_inc_s    = 1'b0;
    state_nxt_s    = RUN;
    wait_cnt_nxt_s = 8'd0;
    if (rst) begin
      hz.pcWrite   = 1'b0;
      hz.ifidWrite = 1'b0;
      hz.idexWrite = 1'b0;
    end else if (hz.memBusy) begin
      hz.pcWrite   = 1'b0;
      hz.ifidWrite = 1'b0;
      hz.idexWrite = 1'b0;
      stall_inc_s  = 1'b1;
      state_nxt_s  = MEM_WAIT;
      case (state_r)
        RUN:      wait_cnt_nxt_s = 8'd1;
        MEM_WAIT: wait_cnt_nxt_s = (wait_cnt_r == 8'hFF) ? 8'hFF : wait_cnt_r + 8'd1;
        default:  wait_cnt_nxt_s = 8'd1;
      endcase
    end else if (hz.branchTaken) begin
      // A taken branch squashes both younger stages, so any load-use stall is moot.
      hz.ifidFlush = 1'b1;
      hz.idexFlush = 1'b1;
      flush_inc_s  = 1'b1;
    end else if (load_use_s) begin
      hz.pcWrite   = 1'b0;
      hz.ifidWrite = 1'b0;
      hz.idexFlush = 1'b1;
      stall_inc_s  = 1'b1;
    end else if (hz.jump) begin
      hz.ifidFlush = 1'b1;
      flush_inc_s  = 1'b1;
    end else begin
      hz.ifidFlush = 1'b0;
    end
  end

  // FSM state and memory-wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Sticky timeout flag and saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_r   <= 1'b0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (timeout_set_s) begin
        timeout_r <= 1'b1;
      end
      if (stall_inc_s && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush_inc_s && (flush_cnt_r != '1)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign hz.memTimeout = timeout_r;
  assign hz.stallCount = stall_cnt_r;
  assign hz.flushCount = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a default instance and a TIMEOUT=3 / 2-bit
// counter instance see identical stimulus; a negedge monitor checks both.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) hz0 ();
  hazard_ctrl_if #(.CNT_W(2))  hz1 ();

  hazard_ctrl #(.TIMEOUT(255), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .hz(hz0.slave));
  hazard_ctrl #(.TIMEOUT(3),   .CNT_W(2))  dut1 (.clk(clk), .rst(rst), .hz(hz1.slave));

  assign hz1.idexMemRead  = hz0.idexMemRead;
  assign hz1.idexWriteReg = hz0.idexWriteReg;
  assign hz1.ifidRs       = hz0.ifidRs;
  assign hz1.ifidRt       = hz0.ifidRt;
  assign hz1.ifidUsesRt   = hz0.ifidUsesRt;
  assign hz1.jump         = hz0.jump;
  assign hz1.branchTaken  = hz0.branchTaken;
  assign hz1.memBusy      = hz0.memBusy;

  typedef struct {
    string      name;
    logic [4:0] ctrl;   // {pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush}
    logic       tmo;
    int         stall;
    int         flush;
    logic       tmo1;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input string what, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s.%s: got %0h expected %0h", name, what, got, want);
    end
  endtask

  // Apply one vector just after a posedge and queue what the monitor must see.
  task automatic vec(input string name, input logic r, input logic [1:0] mr,
                     input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ur, input logic j, input logic bt, input logic mb,
                     input logic [4:0] ctrl, input logic tmo, input int st,
                     input int fl, input logic tmo1);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    hz0.idexMemRead  = mr;
    hz0.idexWriteReg = wr;
    hz0.ifidRs       = rs;
    hz0.ifidRt       = rt;
    hz0.ifidUsesRt   = ur;
    hz0.jump         = j;
    hz0.branchTaken  = bt;
    hz0.memBusy      = mb;
    e.name  = name;
    e.ctrl  = ctrl;
    e.tmo   = tmo;
    e.stall = st;
    e.flush = fl;
    e.tmo1  = tmo1;
    sb.push_back(e);
  endtask

  // Monitor: outputs are stable by the falling edge; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, "ctrl", int'({hz0.pcWrite, hz0.ifidWrite, hz0.ifidFlush,
                                    hz0.idexWrite, hz0.idexFlush}), int'(e.ctrl));
        check(e.name, "memTimeout", int'(hz0.memTimeout), int'(e.tmo));
        check(e.name, "stallCount", int'(hz0.stallCount), e.stall);
        check(e.name, "flushCount", int'(hz0.flushCount), e.flush);
        check(e.name, "ctrl_t3", int'({hz1.pcWrite, hz1.ifidWrite, hz1.ifidFlush,
                                       hz1.idexWrite, hz1.idexFlush}), int'(e.ctrl));
        check(e.name, "memTimeout_t3", int'(hz1.memTimeout), int'(e.tmo1));
        check(e.name, "stallCount_sat", int'(hz1.stallCount), (e.stall > 3) ? 3 : e.stall);
        check(e.name, "flushCount_sat", int'(hz1.flushCount), (e.flush > 3) ? 3 : e.flush);
      end
    end
  end

  initial begin
    hz0.idexMemRead  = 2'd0;
    hz0.idexWriteReg = 5'd0;
    hz0.ifidRs       = 5'd0;
    hz0.ifidRt       = 5'd0;
    hz0.ifidUsesRt   = 1'b0;
    hz0.jump         = 1'b0;
    hz0.branchTaken  = 1'b0;
    hz0.memBusy      = 1'b0;

    //   name           r  mr    wr     rs     rt     ur j  bt mb  ctrl       tmo st fl tmo1
    vec("reset",       1, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    vec("idle",        0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 5'b11010, 0, 0, 0, 0);
    vec("lu_rs",       0, 2'd1, 5'd5,  5'd5,  5'd0,  0, 0, 0, 0, 5'b00011, 0, 0, 0, 0);
    vec("lu_wr0",      0, 2'd1, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 5'b11010, 0, 1, 0, 0);
    vec("lu_rt_nouse", 0, 2'd1, 5'd7,  5'd0,  5'd7,  0, 0, 0, 0, 5'b11010, 0, 1, 0, 0);
    vec("lu_rt_use",   0, 2'd1, 5'd7,  5'd0,  5'd7,  1, 0, 0, 0, 5'b00011, 0, 1, 0, 0);
    vec("no_load",     0, 2'd0, 5'd7,  5'd7,  5'd0,  0, 0, 0, 0, 5'b11010, 0, 2, 0, 0);
    vec("lu_mr2",      0, 2'd2, 5'd9,  5'd9,  5'd0,  0, 0, 0, 0, 5'b00011, 0, 2, 0, 0);
    vec("br_jmp_lu",   0, 2'd1, 5'd5,  5'd5,  5'd0,  0, 1, 1, 0, 5'b11111, 0, 3, 0, 0);
    vec("jump",        0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 0, 5'b11110, 0, 3, 1, 0);
    vec("branch",      0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 5'b11111, 0, 3, 2, 0);
    vec("busy1",       0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 5'b00000, 0, 3, 3, 0);
    vec("busy2_br",    0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 1, 1, 1, 5'b00000, 0, 4, 3, 0);
    vec("busy3_lu",    0, 2'd1, 5'd5,  5'd5,  5'd0,  0, 0, 0, 1, 5'b00000, 0, 5, 3, 0);
    vec("busy4",       0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 5'b00000, 0, 6, 3, 0);
    vec("busy_end",    0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 5'b11010, 0, 7, 3, 1);
    vec("idle2",       0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 5'b11010, 0, 7, 3, 1);
    vec("busy_a",      0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 5'b00000, 0, 7, 3, 1);
    vec("busy_b",      0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 5'b00000, 0, 8, 3, 1);
    vec("rst_mid",     1, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    vec("rst_hold",    1, 2'd1, 5'd5,  5'd5,  5'd0,  0, 1, 1, 1, 5'b00000, 0, 0, 0, 0);
    vec("release",     0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 5'b11010, 0, 0, 0, 0);
    // Ten busy cycles from RUN: the TIMEOUT=3 instance flags after the 4th posedge.
    for (int i = 0; i < 10; i++) begin
      vec($sformatf("tmo_busy%0d", i), 0, 2'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1,
          5'b00000, 0, i, 0, (i >= 4) ? 1'b1 : 1'b0);
    end
    vec("exit_branch", 0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 5'b11111, 0, 10, 0, 1);
    vec("idle3",       0, 2'd0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 5'b11010, 0, 10, 1, 1);

    repeat (4) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, memory-wait cycle count at which memTimeout sets (range 1..255).
REQ-002 Parameter CNT_W, default 16, width of stallCount and flushCount.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 idexMemRead  input  2  MemRead field of instruction in EX; nonzero = load.
REQ-006 idexWriteReg  input  5  destination register of instruction in EX.
REQ-007 ifidRs  input  5  rs field of instruction in ID.
REQ-008 ifidRt  input  5  rt field of instruction in ID.
REQ-009 ifidUsesRt  input  1  instruction in ID reads rt as a source.
REQ-010 jump  input  1  jump decoded in ID.
REQ-011 branchTaken  input  1  branch resolved taken in EX.
REQ-012 memBusy  input  1  data memory not ready; whole pipeline must hold.
REQ-013 pcWrite  output  1  PC load enable.
REQ-014 ifidWrite  output  1  IF/ID register load enable.
REQ-015 ifidFlush  output  1  IF/ID register loads a NOP.
REQ-016 idexWrite  output  1  ID/EX register load enable.
REQ-017 idexFlush  output  1  ID/EX register loads all-zero control fields (bubble).
REQ-018 memTimeout  output  1  sticky; memory wait reached TIMEOUT.
REQ-019 stallCount  output  CNT_W  saturating count of stall cycles.
REQ-020 flushCount  output  CNT_W  saturating count of flush events.

Function
REQ-021 The block SHALL have two states, RUN and MEM_WAIT, plus an 8-bit wait counter waitCnt.
REQ-022 loadUse SHALL equal (idexMemRead!=0) and (idexWriteReg!=0) and (idexWriteReg==ifidRs or (ifidUsesRt and idexWriteReg==ifidRt)).
REQ-023 Control outputs (pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush) SHALL be combinational from state and inputs; evaluated by strict priority P1..P5 below.
REQ-024 P1 memBusy=1: all three write enables 0, both flushes 0; stallCount+1; in RUN go MEM_WAIT with waitCnt<=1; in MEM_WAIT stay, waitCnt+1 saturating at 255.
REQ-025 P2 branchTaken=1: pcWrite=1, ifidWrite=1, idexWrite=1, ifidFlush=1, idexFlush=1; flushCount+1.
REQ-026 P3 loadUse=1: pcWrite=0, ifidWrite=0, idexWrite=1, idexFlush=1, ifidFlush=0; stallCount+1.
REQ-027 P4 jump=1: pcWrite=1, ifidWrite=1, idexWrite=1, ifidFlush=1, idexFlush=0; flushCount+1.
REQ-028 P5 otherwise: all write enables 1, both flushes 0, counters unchanged.
REQ-029 In MEM_WAIT with memBusy=0, P2..P5 SHALL apply in that same cycle and next state SHALL be RUN, waitCnt<=0.
REQ-030 memTimeout SHALL set on the posedge where memBusy=1 in MEM_WAIT and waitCnt>=TIMEOUT, and stay set until rst.
REQ-031 branchTaken and jump together SHALL increment flushCount once (P2 only); branchTaken with loadUse SHALL not stall.
REQ-032 stallCount and flushCount SHALL saturate at all-ones and never wrap.
REQ-033 Latency: control outputs respond in the same cycle as inputs; counters/state/memTimeout update at the next posedge.

Reset
REQ-034 While rst=1: state=RUN, waitCnt=0, memTimeout=0, stallCount=0, flushCount=0, pcWrite=ifidWrite=idexWrite=0, ifidFlush=idexFlush=0, regardless of clk.
REQ-035 rst asserted in MEM_WAIT SHALL abort the wait immediately; after release the block SHALL be in RUN and apply P1..P5.

Verification
REQ-036 idexMemRead=1, idexWriteReg=5, ifidRs=5 -> pcWrite=0, ifidWrite=0, idexFlush=1 for one cycle; stallCount 0->1; idexWriteReg=0 instead -> no stall.
REQ-037 idexMemRead=1, idexWriteReg=7, ifidRt=7, ifidUsesRt=0 -> no stall; ifidUsesRt=1 -> stall.
REQ-038 branchTaken=1, jump=1, loadUse=1 same cycle -> ifidFlush=1, idexFlush=1, pcWrite=1; flushCount+1, stallCount unchanged.
REQ-039 memBusy=1 for 4 cycles -> all enables 0 for 4 cycles, stallCount=4, return to RUN on 5th cycle with P5 outputs; memTimeout=0.
REQ-040 TIMEOUT=3, memBusy held 10 cycles -> memTimeout=1 by 4th posedge, remains 1 after memBusy=0; cleared only by rst.
REQ-041 rst pulsed mid-MEM_WAIT and mid-clock with counters nonzero -> all outputs zero immediately, counters zero, RUN after release.
